// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared definitions for the breathing-LED level sequencer and the PWM stage
// that consumes its level.
//   LEVEL_W_DEF  : default brightness level width (matches the PWM level input)
//   PRESCALE_DEF : default number of clk cycles per sequencing tick
//   fade_state_e : sequencer FSM state encoding
//   pwm_level_t  : brightness level type shared with the PWM comparator
// -----------------------------------------------------------------------------
package led_pkg;

    localparam int LEVEL_W_DEF  = 7;
    localparam int PRESCALE_DEF = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FADE = 2'd1,
        ST_HOLD = 2'd2
    } fade_state_e;

    typedef logic [LEVEL_W_DEF-1:0] pwm_level_t;

endpackage

// File: rtl/led_fade_seq_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Free-running counter 0..PRESCALE-1 that wraps forever. o_tick is high for
// the one clk cycle in which the count equals PRESCALE-1. Only rst_n clears it.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   o_tick     : one-cycle tick strobe, period PRESCALE clk cycles
// -----------------------------------------------------------------------------
module tick_prescaler
    import led_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEF
)(
    input  logic clk,
    input  logic rst_n,
    output logic o_tick
);

    localparam int            CW   = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_tick;

    // Next count with wrap at PRESCALE-1.
    always_comb begin
        if (r_cnt == LAST) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt + ONE;
        end
    end

    // Counter plus a registered tick that is high exactly while the count is LAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_tick <= (w_cnt_nxt == LAST);
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/led_fade_seq.sv
// -----------------------------------------------------------------------------
// led_fade_seq
// Level source for the breathing-LED PWM stage. Holds a DEPTH-entry table of
// brightness levels, ramps the output one LSB per tick toward each entry,
// holds there for dwell+1 ticks and moves to the next entry, wrapping after
// the active sequence length.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_wr_valid    : table write request (stalled outside IDLE)
//   o_wr_ready    : table write accept, high only in IDLE
//   i_wr_addr     : table entry index
//   i_wr_level    : level to store
//   i_run         : level-sensitive sequencing enable
//   i_seq_len     : active entries (0 -> 1, >DEPTH -> DEPTH), sampled live
//   i_dwell       : hold ticks per entry minus one
//   o_level       : current brightness to the PWM comparator
//   o_level_stb   : one-cycle pulse in the cycle after o_level changes
//   o_step_idx    : index of current target entry
//   o_busy        : high when not IDLE
// -----------------------------------------------------------------------------
module led_fade_seq
    import led_pkg::*;
#(
    parameter int LEVEL_W  = LEVEL_W_DEF,
    parameter int DEPTH    = 8,
    parameter int AW       = 3,
    parameter int DWELL_W  = 8,
    parameter int PRESCALE = PRESCALE_DEF
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_wr_valid,
    output logic               o_wr_ready,
    input  logic [AW-1:0]      i_wr_addr,
    input  logic [LEVEL_W-1:0] i_wr_level,
    input  logic               i_run,
    input  logic [AW:0]        i_seq_len,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic [LEVEL_W-1:0] o_level,
    output logic               o_level_stb,
    output logic [AW-1:0]      o_step_idx,
    output logic               o_busy
);

    localparam logic [AW:0]        DEPTH_L   = (AW+1)'(DEPTH);
    localparam logic [AW:0]        LEN_ONE   = (AW+1)'(1);
    localparam logic [LEVEL_W-1:0] LVL_ONE   = LEVEL_W'(1);
    localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);
    localparam logic [AW-1:0]      IDX_ZERO  = '0;

    logic [LEVEL_W-1:0] r_table [DEPTH];

    fade_state_e        r_state;
    fade_state_e        w_state_nxt;
    logic [LEVEL_W-1:0] r_level;
    logic [LEVEL_W-1:0] w_level_nxt;
    logic [LEVEL_W-1:0] r_target;
    logic [LEVEL_W-1:0] w_target_nxt;
    logic [AW-1:0]      r_step_idx;
    logic [AW-1:0]      w_idx_nxt;
    logic [DWELL_W-1:0] r_dwell_cnt;
    logic [DWELL_W-1:0] w_dwell_nxt;
    logic               r_level_stb;
    logic               r_busy;
    logic               r_wr_ready;

    logic               w_tick;
    logic               w_wr_en;
    logic [AW:0]        w_eff_len;
    logic [AW:0]        w_idx_inc;
    logic [AW-1:0]      w_wrap_idx;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_tick (w_tick)
    );

    // r_wr_ready mirrors "state is IDLE", so writes only land while idle.
    assign w_wr_en = i_wr_valid & r_wr_ready;

    // Clamp the live sequence length into 1..DEPTH.
    always_comb begin
        if (i_seq_len == '0) begin
            w_eff_len = LEN_ONE;
        end else if (i_seq_len > DEPTH_L) begin
            w_eff_len = DEPTH_L;
        end else begin
            w_eff_len = i_seq_len;
        end
    end

    // Next entry index; >= (not ==) so a shrunken seq_len still wraps cleanly.
    assign w_idx_inc = {1'b0, r_step_idx} + LEN_ONE;

    // Wrap decision for the step that follows a finished hold.
    always_comb begin
        if (w_idx_inc >= w_eff_len) begin
            w_wrap_idx = IDX_ZERO;
        end else begin
            w_wrap_idx = w_idx_inc[AW-1:0];
        end
    end

    // Level table; cleared by reset, written only from IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_table[i_wr_addr] <= i_wr_level;
        end
    end

    // Sequencer next-state: run=0 always wins over a coincident tick.
    always_comb begin
        w_state_nxt  = r_state;
        w_level_nxt  = r_level;
        w_target_nxt = r_target;
        w_idx_nxt    = r_step_idx;
        w_dwell_nxt  = r_dwell_cnt;
        case (r_state)
            ST_IDLE: begin
                if (i_run) begin
                    w_idx_nxt    = IDX_ZERO;
                    w_target_nxt = r_table[IDX_ZERO];
                    w_state_nxt  = ST_FADE;
                end else begin
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_FADE: begin
                if (!i_run) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tick) begin
                    if (r_level < r_target) begin
                        w_level_nxt = r_level + LVL_ONE;
                    end else if (r_level > r_target) begin
                        w_level_nxt = r_level - LVL_ONE;
                    end else begin
                        w_dwell_nxt = i_dwell;
                        w_state_nxt = ST_HOLD;
                    end
                end else begin
                    w_state_nxt = ST_FADE;
                end
            end
            ST_HOLD: begin
                if (!i_run) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tick) begin
                    if (r_dwell_cnt != '0) begin
                        w_dwell_nxt = r_dwell_cnt - DWELL_ONE;
                    end else begin
                        w_idx_nxt    = w_wrap_idx;
                        w_target_nxt = r_table[w_wrap_idx];
                        w_state_nxt  = ST_FADE;
                    end
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and registered outputs; stb flags any edge that moved level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_level     <= '0;
            r_target    <= '0;
            r_step_idx  <= '0;
            r_dwell_cnt <= '0;
            r_level_stb <= 1'b0;
            r_busy      <= 1'b0;
            r_wr_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_level     <= w_level_nxt;
            r_target    <= w_target_nxt;
            r_step_idx  <= w_idx_nxt;
            r_dwell_cnt <= w_dwell_nxt;
            r_level_stb <= (w_level_nxt != r_level);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_wr_ready  <= (w_state_nxt == ST_IDLE);
        end
    end

    assign o_level     = r_level;
    assign o_level_stb = r_level_stb;
    assign o_step_idx  = r_step_idx;
    assign o_busy      = r_busy;
    assign o_wr_ready  = r_wr_ready;

endmodule

// File: tb/tb_led_fade_seq.sv
// -----------------------------------------------------------------------------
// tb_led_fade_seq
// Directed bench for led_fade_seq with PRESCALE=4, DEPTH=8. The bench keeps
// its own count of clk edges since reset release; with PRESCALE=4 the FSM acts
// on a tick at every edge whose count is a multiple of 4.
// -----------------------------------------------------------------------------
module tb_led_fade_seq;

    localparam int LEVEL_W  = 7;
    localparam int DEPTH    = 8;
    localparam int AW       = 3;
    localparam int DWELL_W  = 8;
    localparam int PRESCALE = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               i_wr_valid;
    logic               o_wr_ready;
    logic [AW-1:0]      i_wr_addr;
    logic [LEVEL_W-1:0] i_wr_level;
    logic               i_run;
    logic [AW:0]        i_seq_len;
    logic [DWELL_W-1:0] i_dwell;
    logic [LEVEL_W-1:0] o_level;
    logic               o_level_stb;
    logic [AW-1:0]      o_step_idx;
    logic               o_busy;

    int n_edge;
    int n_checks;
    int n_fail;
    int stb_cnt;

    // Expected level / index after each tick of the {5,2,5} sequence, dwell=0.
    int seq_lvl [18] = '{1, 2, 3, 4, 5, 5, 5, 4, 3, 2, 2, 2, 3, 4, 5, 5, 5, 5};
    int seq_idx [18] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 0, 0};
    // Expected after each tick when restarting at level 5 over {5,9}, seq_len=2.
    int gat_lvl [6]  = '{5, 5, 6, 7, 8, 9};
    int gat_idx [6]  = '{0, 1, 1, 1, 1, 1};

    led_fade_seq #(
        .LEVEL_W  (LEVEL_W),
        .DEPTH    (DEPTH),
        .AW       (AW),
        .DWELL_W  (DWELL_W),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wr_valid  (i_wr_valid),
        .o_wr_ready  (o_wr_ready),
        .i_wr_addr   (i_wr_addr),
        .i_wr_level  (i_wr_level),
        .i_run       (i_run),
        .i_seq_len   (i_seq_len),
        .i_dwell     (i_dwell),
        .o_level     (o_level),
        .o_level_stb (o_level_stb),
        .o_step_idx  (o_step_idx),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        n_edge++;
        if (o_level_stb === 1'b1) stb_cnt++;
    endtask

    task automatic cycles(input int k);
        for (int i = 0; i < k; i++) cyc();
    endtask

    task automatic to_tick();
        do cyc(); while ((n_edge % PRESCALE) != 0);
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) to_tick();
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [LEVEL_W-1:0] l);
        i_wr_valid = 1'b1;
        i_wr_addr  = a;
        i_wr_level = l;
        cyc();
        i_wr_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n  = 1'b1;
        n_edge = 0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; n_edge = 0; stb_cnt = 0;
        rst_n = 1'b0; i_wr_valid = 1'b0; i_wr_addr = 3'd0; i_wr_level = 7'd0;
        i_run = 1'b0; i_seq_len = 4'd1; i_dwell = 8'd0;
        #12;
        chk("rst_level",    o_level,     32'd0);
        chk("rst_stb",      o_level_stb, 32'd0);
        chk("rst_busy",     o_busy,      32'd0);
        chk("rst_wr_ready", o_wr_ready,  32'd1);
        chk("rst_idx",      o_step_idx,  32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        n_edge = 0;

        // Basic ramp 0->3, dwell 2, single entry.
        wr(3'd0, 7'd3);
        i_seq_len = 4'd1; i_dwell = 8'd2; stb_cnt = 0; i_run = 1'b1;
        cyc();
        chk("ramp_busy",     o_busy,      32'd1);
        chk("ramp_wr_ready", o_wr_ready,  32'd0);
        chk("ramp_l0",       o_level,     32'd0);
        to_tick();
        chk("ramp_l1",       o_level,     32'd1);
        chk("ramp_stb1",     o_level_stb, 32'd1);
        cyc();
        chk("ramp_stb_drop", o_level_stb, 32'd0);
        to_tick();
        chk("ramp_l2",       o_level,     32'd2);
        to_tick();
        chk("ramp_l3",       o_level,     32'd3);
        cycles(40);
        chk("ramp_l3_held",  o_level,     32'd3);
        chk("ramp_stb_cnt",  stb_cnt,     32'd3);
        chk("ramp_idx",      o_step_idx,  32'd0);
        i_run = 1'b0;
        cyc();
        chk("ramp_stop_busy",  o_busy,  32'd0);
        chk("ramp_stop_level", o_level, 32'd3);

        // Sequence wrap over {5,2,5}, dwell 0.
        do_reset();
        chk("seq_rst_level", o_level, 32'd0);
        wr(3'd0, 7'd5); wr(3'd1, 7'd2); wr(3'd2, 7'd5);
        i_seq_len = 4'd3; i_dwell = 8'd0; i_run = 1'b1;
        cyc();
        for (int t = 0; t < 18; t++) begin
            to_tick();
            chk($sformatf("seq_lvl_t%0d", t + 1), o_level,    seq_lvl[t]);
            chk($sformatf("seq_idx_t%0d", t + 1), o_step_idx, seq_idx[t]);
        end

        // Write gating: stalled while running, commits once idle.
        i_wr_valid = 1'b1; i_wr_addr = 3'd1; i_wr_level = 7'd9;
        cyc();
        chk("gate_wr_ready_run", o_wr_ready, 32'd0);
        i_run = 1'b0;
        cyc();
        chk("gate_wr_ready_idle", o_wr_ready, 32'd1);
        chk("gate_busy",          o_busy,     32'd0);
        chk("gate_level_frozen",  o_level,    32'd5);
        chk("gate_idx_frozen",    o_step_idx, 32'd0);
        cyc();
        i_wr_valid = 1'b0;
        i_seq_len = 4'd2; i_run = 1'b1;
        cyc();
        for (int t = 0; t < 6; t++) begin
            to_tick();
            chk($sformatf("gate_lvl_t%0d", t + 1), o_level,    gat_lvl[t]);
            chk($sformatf("gate_idx_t%0d", t + 1), o_step_idx, gat_idx[t]);
        end
        i_run = 1'b0;
        cyc();

        // Pause at 4 heading to 10, then restart from the frozen level.
        do_reset();
        wr(3'd0, 7'd10);
        i_seq_len = 4'd1; i_dwell = 8'd0; i_run = 1'b1;
        cyc();
        ticks(4);
        chk("pause_l4", o_level, 32'd4);
        i_run = 1'b0;
        cyc();
        chk("pause_busy",  o_busy,      32'd0);
        chk("pause_level", o_level,     32'd4);
        chk("pause_stb",   o_level_stb, 32'd0);
        stb_cnt = 0;
        cycles(8);
        chk("pause_frozen", o_level, 32'd4);
        chk("pause_no_stb", stb_cnt, 32'd0);
        i_run = 1'b1;
        cyc();
        chk("restart_busy",  o_busy,     32'd1);
        chk("restart_idx",   o_step_idx, 32'd0);
        chk("restart_level", o_level,    32'd4);
        to_tick();
        chk("restart_l5", o_level, 32'd5);
        to_tick();
        chk("restart_l6",  o_level,     32'd6);
        chk("restart_stb", o_level_stb, 32'd1);

        // Asynchronous reset in the middle of a fade.
        rst_n = 1'b0;
        #2;
        chk("arst_level",    o_level,     32'd0);
        chk("arst_stb",      o_level_stb, 32'd0);
        chk("arst_busy",     o_busy,      32'd0);
        chk("arst_wr_ready", o_wr_ready,  32'd1);
        @(negedge clk);
        rst_n  = 1'b1;
        n_edge = 0;
        stb_cnt = 0;
        cyc();
        ticks(5);
        chk("zero_tbl_level", o_level, 32'd0);
        chk("zero_tbl_stb",   stb_cnt, 32'd0);
        chk("zero_tbl_busy",  o_busy,  32'd1);
        i_run = 1'b0;
        cyc();

        // Top level, 256-tick hold, then run=0 coincident with a tick.
        wr(3'd0, 7'd127); wr(3'd1, 7'd126);
        i_seq_len = 4'd2; i_dwell = 8'd255; i_run = 1'b1;
        cyc();
        ticks(126);
        chk("bnd_l126", o_level, 32'd126);
        ticks(1);
        chk("bnd_l127", o_level, 32'd127);
        ticks(1);
        chk("bnd_no_overflow", o_level, 32'd127);
        ticks(255);
        chk("bnd_hold_idx",   o_step_idx, 32'd0);
        chk("bnd_hold_level", o_level,    32'd127);
        ticks(1);
        chk("bnd_next_idx",   o_step_idx, 32'd1);
        chk("bnd_next_level", o_level,    32'd127);
        cycles(3);
        i_run = 1'b0;
        cyc();
        chk("coinc_level", o_level,     32'd127);
        chk("coinc_busy",  o_busy,      32'd0);
        chk("coinc_stb",   o_level_stb, 32'd0);
        chk("coinc_idx",   o_step_idx,  32'd1);

        // seq_len=0 acts as a single entry.
        i_seq_len = 4'd0; i_dwell = 8'd0; i_run = 1'b1;
        cyc();
        ticks(2);
        chk("sl0_idx_t2", o_step_idx, 32'd0);
        ticks(1);
        chk("sl0_lvl_t3", o_level,    32'd127);
        chk("sl0_idx_t3", o_step_idx, 32'd0);
        i_run = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
